i2c_master_arbiter: RTL

//  Round-robin scheduler that shares one i2c_master among NUM_REQ requesters (sensor pollers, config loaders).

---
 rtl/i2c_master_arbiter_pkg.sv | 30 +++
 rtl/i2c_master_arbiter_rr.sv | 36 +++
 rtl/i2c_master_arbiter.sv | 215 +++++++++++++++++++++
 3 files changed

// File: rtl/i2c_master_arbiter_pkg.sv
// Shared definitions for the i2c_master round-robin arbiter: FSM states and
// i2c_master control/mode/status bit positions.
package i2c_master_arbiter_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ARB,
        ST_START,
        ST_WAIT_BUSY,
        ST_ACTIVE,
        ST_CLEAR,
        ST_DONE
    } arb_state_e;

    // i2c_master o_status_reg layout: {BUSY,TX_DONE,RX_DONE,TX_ERR,RX_ERR}
    localparam int STAT_BUSY   = 4;
    localparam int STAT_TX_DONE = 3;
    localparam int STAT_RX_DONE = 2;
    localparam int STAT_TX_ERR = 1;
    localparam int STAT_RX_ERR = 0;

    localparam int CTRL_START  = 3;
    localparam int CTRL_CLEAR  = 2;
    localparam int MODE_ADDR10 = 3;
    localparam int MODE_READ   = 2;

    // Reported for aborted or never-started transactions (both error bits).
    localparam logic [4:0] STATUS_ABORT = 5'b00011;

endpackage

// File: rtl/i2c_master_arbiter_rr.sv
// Combinational round-robin priority rotate: grants the first request at or
// after ptr_i, wrapping to index 0.
module i2c_master_arbiter_rr #(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = 2
) (
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [IDX_W-1:0]   ptr_i,
    output logic [NUM_REQ-1:0] gnt_o,
    output logic [IDX_W-1:0]   idx_o
);

    logic found;

    // Two constant-index passes: upper segment [ptr..N-1] first, then [0..ptr-1].
    always_comb begin
        gnt_o = '0;
        idx_o = '0;
        found = 1'b0;
        for (int c = 0; c < NUM_REQ; c++) begin
            if (!found && req_i[c] && (IDX_W'(c) >= ptr_i)) begin
                gnt_o[c] = 1'b1;
                idx_o    = IDX_W'(c);
                found    = 1'b1;
            end
        end
        for (int c = 0; c < NUM_REQ; c++) begin
            if (!found && req_i[c] && (IDX_W'(c) < ptr_i)) begin
                gnt_o[c] = 1'b1;
                idx_o    = IDX_W'(c);
                found    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/i2c_master_arbiter.sv
// Shares one i2c_master among NUM_REQ requesters: round-robin grant, descriptor
// latch, start/clear sequencing with busy-wait and watchdog aborts, result routing.
module i2c_master_arbiter
    import i2c_master_arbiter_pkg::*;
#(
    parameter int NUM_REQ     = 4,
    parameter int WDOG_CYCLES = 2000000,
    parameter int BUSY_WAIT   = 64
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic [NUM_REQ-1:0]    i_req,
    input  logic [NUM_REQ*10-1:0] i_req_addr,
    input  logic [NUM_REQ*8-1:0]  i_req_byte_cnt,
    input  logic [NUM_REQ*2-1:0]  i_req_mode,
    input  logic [NUM_REQ*8-1:0]  i_req_tx_data,
    output logic [NUM_REQ-1:0]    o_gnt,
    output logic [NUM_REQ-1:0]    o_tx_data_needed,
    output logic [NUM_REQ-1:0]    o_rx_data_valid,
    output logic [7:0]            o_rx_data,
    output logic [NUM_REQ-1:0]    o_done,
    output logic [4:0]            o_status,
    output logic                  o_timeout,
    output logic [9:0]            m_slave_addr,
    output logic [7:0]            m_byte_cnt,
    output logic [3:0]            m_control,
    output logic [3:0]            m_mode,
    output logic [7:0]            m_tx_data,
    input  logic                  m_tx_data_needed,
    input  logic                  m_rx_data_valid,
    input  logic [7:0]            m_rx_data,
    input  logic [4:0]            m_status
);

    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int CNT_MAX = (WDOG_CYCLES > BUSY_WAIT) ? WDOG_CYCLES : BUSY_WAIT;
    localparam int CNT_W = $clog2(CNT_MAX + 1);
    localparam logic [CNT_W-1:0] BUSY_LAST = CNT_W'(BUSY_WAIT - 1);
    localparam logic [CNT_W-1:0] WDOG_LAST = CNT_W'(WDOG_CYCLES - 1);
    localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(NUM_REQ - 1);

    arb_state_e          state_q, state_d;
    logic [IDX_W-1:0]    ptr_q, ptr_d;
    logic [IDX_W-1:0]    own_q, own_d;
    logic [NUM_REQ-1:0]  gnt_q, gnt_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [9:0]          addr_q, addr_d;
    logic [7:0]          bcnt_q, bcnt_d;
    logic [1:0]          mode_q, mode_d;
    logic [4:0]          status_q, status_d;
    logic                tmo_q, tmo_d;

    logic [NUM_REQ-1:0]  arb_gnt;
    logic [IDX_W-1:0]    arb_idx;
    logic [IDX_W-1:0]    cur_idx;
    logic [9:0]          sel_addr;
    logic [7:0]          sel_bcnt;
    logic [1:0]          sel_mode;
    logic [7:0]          sel_tx;
    logic                owned;
    logic                tx_live;

    i2c_master_arbiter_rr #(
        .NUM_REQ(NUM_REQ),
        .IDX_W  (IDX_W)
    ) u_rr (
        .req_i (i_req),
        .ptr_i (ptr_q),
        .gnt_o (arb_gnt),
        .idx_o (arb_idx)
    );

    assign owned   = (state_q == ST_START) || (state_q == ST_WAIT_BUSY) ||
                     (state_q == ST_ACTIVE) || (state_q == ST_CLEAR);
    assign tx_live = owned || ((state_q == ST_ARB) && (|arb_gnt));
    assign cur_idx = (state_q == ST_ARB) ? arb_idx : own_q;

    // Descriptor slices follow the arbiter's pick; tx data follows the owner live.
    always_comb begin
        sel_addr = '0;
        sel_bcnt = '0;
        sel_mode = '0;
        sel_tx   = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (IDX_W'(k) == arb_idx) begin
                sel_addr = i_req_addr[10*k +: 10];
                sel_bcnt = i_req_byte_cnt[8*k +: 8];
                sel_mode = i_req_mode[2*k +: 2];
            end
            if (IDX_W'(k) == cur_idx) begin
                sel_tx = i_req_tx_data[8*k +: 8];
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        ptr_d    = ptr_q;
        own_d    = own_q;
        gnt_d    = gnt_q;
        cnt_d    = cnt_q;
        addr_d   = addr_q;
        bcnt_d   = bcnt_q;
        mode_d   = mode_q;
        status_d = status_q;
        tmo_d    = tmo_q;

        case (state_q)
            ST_IDLE: begin
                if (|i_req) state_d = ST_ARB;
            end
            ST_ARB: begin
                if (|arb_gnt) begin
                    gnt_d  = arb_gnt;
                    own_d  = arb_idx;
                    addr_d = sel_addr;
                    bcnt_d = sel_bcnt;
                    mode_d = sel_mode;
                    cnt_d  = '0;
                    tmo_d  = 1'b0;
                    // A zero-length request is reported as failed without touching the master.
                    if (sel_bcnt == 8'd0) begin
                        status_d = STATUS_ABORT;
                        state_d  = ST_DONE;
                    end else begin
                        state_d  = ST_START;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_START: begin
                cnt_d   = '0;
                state_d = ST_WAIT_BUSY;
            end
            ST_WAIT_BUSY: begin
                if (m_status[STAT_BUSY]) begin
                    cnt_d   = cnt_q + 1'b1;
                    state_d = ST_ACTIVE;
                end else if (cnt_q == BUSY_LAST) begin
                    status_d = STATUS_ABORT;
                    tmo_d    = 1'b1;
                    state_d  = ST_CLEAR;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_ACTIVE: begin
                // The watchdog keeps counting from the start pulse, not from BUSY rise.
                if (!m_status[STAT_BUSY]) begin
                    status_d = m_status;
                    state_d  = ST_CLEAR;
                end else if (cnt_q == WDOG_LAST) begin
                    status_d = STATUS_ABORT;
                    tmo_d    = 1'b1;
                    state_d  = ST_CLEAR;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_CLEAR: begin
                state_d = ST_DONE;
            end
            ST_DONE: begin
                ptr_d   = (own_q == LAST_IDX) ? '0 : own_q + 1'b1;
                gnt_d   = '0;
                state_d = (|i_req) ? ST_ARB : ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q  <= ST_IDLE;
            ptr_q    <= '0;
            own_q    <= '0;
            gnt_q    <= '0;
            cnt_q    <= '0;
            addr_q   <= '0;
            bcnt_q   <= '0;
            mode_q   <= '0;
            status_q <= '0;
            tmo_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            ptr_q    <= ptr_d;
            own_q    <= own_d;
            gnt_q    <= gnt_d;
            cnt_q    <= cnt_d;
            addr_q   <= addr_d;
            bcnt_q   <= bcnt_d;
            mode_q   <= mode_d;
            status_q <= status_d;
            tmo_q    <= tmo_d;
        end
    end

    assign o_gnt            = (state_q == ST_ARB) ? arb_gnt : (owned ? gnt_q : '0);
    assign o_tx_data_needed = owned ? (gnt_q & {NUM_REQ{m_tx_data_needed}}) : '0;
    assign o_rx_data_valid  = owned ? (gnt_q & {NUM_REQ{m_rx_data_valid}}) : '0;
    assign o_rx_data        = m_rx_data;
    assign o_done           = (state_q == ST_DONE) ? gnt_q : '0;
    assign o_status         = status_q;
    assign o_timeout        = (state_q == ST_DONE) && tmo_q;

    assign m_slave_addr = addr_q;
    assign m_byte_cnt   = bcnt_q;
    assign m_mode       = {mode_q, 2'b00};
    assign m_control    = {state_q == ST_START, state_q == ST_CLEAR, 2'b00};
    assign m_tx_data    = tx_live ? sel_tx : 8'h00;

endmodule
